// File: rtl/rtc_sched_pkg.sv
// rtl/rtc_sched_pkg.sv - PCF8563 register map, field masks and scheduler state types
package rtc_sched_pkg;

  localparam int         NUM_REGS = 7;
  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  localparam logic [7:0] REG_SEC   = 8'h02;
  localparam logic [7:0] REG_MIN   = 8'h03;
  localparam logic [7:0] REG_HOUR  = 8'h04;
  localparam logic [7:0] REG_DAY   = 8'h05;
  localparam logic [7:0] REG_WDAY  = 8'h06;
  localparam logic [7:0] REG_MONTH = 8'h07;
  localparam logic [7:0] REG_YEAR  = 8'h08;

  localparam logic [7:0] MASK_SEC   = 8'h7F;
  localparam logic [7:0] MASK_MIN   = 8'h7F;
  localparam logic [7:0] MASK_HOUR  = 8'h3F;
  localparam logic [7:0] MASK_DAY   = 8'h3F;
  localparam logic [7:0] MASK_WDAY  = 8'h07;
  localparam logic [7:0] MASK_MONTH = 8'h1F;
  localparam logic [7:0] MASK_YEAR  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_NEXT, S_COMMIT, S_ERR
  } state_e;

  typedef enum logic {OP_RD, OP_WR} op_e;

  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_addr = REG_SEC;
      3'd1:    reg_addr = REG_MIN;
      3'd2:    reg_addr = REG_HOUR;
      3'd3:    reg_addr = REG_DAY;
      3'd4:    reg_addr = REG_WDAY;
      3'd5:    reg_addr = REG_MONTH;
      default: reg_addr = REG_YEAR;
    endcase
  endfunction

  // Month mask also drops the century bit, so writes always send it as 0.
  function automatic logic [7:0] reg_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_mask = MASK_SEC;
      3'd1:    reg_mask = MASK_MIN;
      3'd2:    reg_mask = MASK_HOUR;
      3'd3:    reg_mask = MASK_DAY;
      3'd4:    reg_mask = MASK_WDAY;
      3'd5:    reg_mask = MASK_MONTH;
      default: reg_mask = MASK_YEAR;
    endcase
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// rtl/rtc_poll_timer.sv - free-running divider giving a one-cycle tick every PERIOD cycles
module rtc_poll_timer #(
  parameter int PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_access_sched.sv
// rtl/rtc_access_sched.sv - PCF8563 poll/set-time burst scheduler over a single-register I2C engine
// Optional voltage-low tracking is built when RTC_VL_CHECK_EN is defined.
module rtc_access_sched
  import rtc_sched_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int POLL_HZ     = 4,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  output logic        wr_ready,
  input  logic [23:0] wr_time,
  input  logic [31:0] wr_date,
  output logic        i2c_req,
  output logic        i2c_rnw,
  output logic [7:0]  i2c_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_ack_err,
  output logic [23:0] time_read,
  output logic [31:0] date_read,
  output logic        read_done,
  output logic        wr_done,
  output logic        err,
  output logic        vl_flag
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC);

  state_e                      state_q, state_d;
  op_e                         op_q, op_d;
  logic                        poll_pend_q, poll_pend_d;
  logic                        wr_pend_q, wr_pend_d;
  logic                        wr_busy_q, wr_busy_d;
  logic [2:0]                  byte_q, byte_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [NUM_REGS-1:0][7:0]    pay_q, pay_d;
  logic [NUM_REGS-1:0][7:0]    shadow_q, shadow_d;
  logic                        i2c_req_q, i2c_req_d;
  logic                        i2c_rnw_q, i2c_rnw_d;
  logic [7:0]                  i2c_addr_q, i2c_addr_d;
  logic [7:0]                  i2c_wdata_q, i2c_wdata_d;
  logic [23:0]                 time_q, time_d;
  logic [31:0]                 date_q, date_d;
  logic                        tick, wr_rise, wr_accept;
`ifdef RTC_VL_CHECK_EN
  logic                        vl_raw_q, vl_raw_d;
  logic                        vl_q, vl_d;
`endif

  rtc_poll_timer #(.PERIOD(CLK_HZ / POLL_HZ)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // The cycle wr_ready re-rises ignores wr_req so the host sees one clean handshake.
  assign wr_rise   = (state_q == S_COMMIT || state_q == S_ERR) && (op_q == OP_WR);
  assign wr_accept = wr_req && !wr_busy_q && !wr_rise;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    poll_pend_d = poll_pend_q | tick;
    wr_pend_d   = wr_pend_q;
    wr_busy_d   = wr_busy_q;
    byte_d      = byte_q;
    to_cnt_d    = to_cnt_q;
    pay_d       = pay_q;
    shadow_d    = shadow_q;
    i2c_req_d   = 1'b0;
    i2c_rnw_d   = i2c_rnw_q;
    i2c_addr_d  = i2c_addr_q;
    i2c_wdata_d = i2c_wdata_q;
    time_d      = time_q;
    date_d      = date_q;
`ifdef RTC_VL_CHECK_EN
    vl_raw_d    = vl_raw_q;
    vl_d        = vl_q;
`endif

    if (wr_accept) begin
      wr_busy_d = 1'b1;
      wr_pend_d = 1'b1;
      pay_d     = {wr_date[31:24], wr_date[23:16], wr_date[7:0], wr_date[15:8],
                   wr_time[23:16], wr_time[15:8], wr_time[7:0]};
    end

    case (state_q)
      S_IDLE: if (wr_pend_q || poll_pend_q) state_d = S_ARB;
      S_ARB: begin
        if (wr_pend_q) begin
          op_d      = OP_WR;
          wr_pend_d = 1'b0;
        end else begin
          op_d        = OP_RD;
          poll_pend_d = tick;
        end
        byte_d  = 3'd0;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (!i2c_busy) begin
        i2c_req_d   = 1'b1;
        i2c_rnw_d   = (op_q == OP_RD);
        i2c_addr_d  = reg_addr(byte_q);
        i2c_wdata_d = (op_q == OP_WR) ? (pay_q[byte_q] & reg_mask(byte_q)) : 8'h00;
        to_cnt_d    = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            state_d = S_ERR;
          end else begin
            if (op_q == OP_RD) begin
              shadow_d[byte_q] = i2c_rdata & reg_mask(byte_q);
`ifdef RTC_VL_CHECK_EN
              if (byte_q == 3'd0) vl_raw_d = i2c_rdata[7];
`endif
            end
            state_d = S_NEXT;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_LAST) state_d = S_ERR;
        end
      end
      S_NEXT: begin
        if (byte_q == LAST_IDX) begin
          // Loaded here so the visible outputs change in the COMMIT cycle itself.
          if (op_q == OP_RD) begin
            time_d = {shadow_q[2], shadow_q[1], shadow_q[0]};
            date_d = {shadow_q[6], shadow_q[5], shadow_q[3], shadow_q[4]};
          end
`ifdef RTC_VL_CHECK_EN
          vl_d = (op_q == OP_RD) ? vl_raw_q : 1'b0;
`endif
          state_d = S_COMMIT;
        end else begin
          byte_d  = byte_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if ((state_d == S_COMMIT || state_d == S_ERR) && op_q == OP_WR) wr_busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RD;
      poll_pend_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      byte_q      <= 3'd0;
      to_cnt_q    <= '0;
      pay_q       <= '0;
      shadow_q    <= '0;
      i2c_req_q   <= 1'b0;
      i2c_rnw_q   <= 1'b0;
      i2c_addr_q  <= 8'h00;
      i2c_wdata_q <= 8'h00;
      time_q      <= 24'h0;
      date_q      <= 32'h0;
`ifdef RTC_VL_CHECK_EN
      vl_raw_q    <= 1'b0;
      vl_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      poll_pend_q <= poll_pend_d;
      wr_pend_q   <= wr_pend_d;
      wr_busy_q   <= wr_busy_d;
      byte_q      <= byte_d;
      to_cnt_q    <= to_cnt_d;
      pay_q       <= pay_d;
      shadow_q    <= shadow_d;
      i2c_req_q   <= i2c_req_d;
      i2c_rnw_q   <= i2c_rnw_d;
      i2c_addr_q  <= i2c_addr_d;
      i2c_wdata_q <= i2c_wdata_d;
      time_q      <= time_d;
      date_q      <= date_d;
`ifdef RTC_VL_CHECK_EN
      vl_raw_q    <= vl_raw_d;
      vl_q        <= vl_d;
`endif
    end
  end

  assign wr_ready  = !wr_busy_q;
  assign i2c_req   = i2c_req_q;
  assign i2c_rnw   = i2c_rnw_q;
  assign i2c_addr  = i2c_addr_q;
  assign i2c_wdata = i2c_wdata_q;
  assign time_read = time_q;
  assign date_read = date_q;
  assign read_done = (state_q == S_COMMIT) && (op_q == OP_RD);
  assign wr_done   = (state_q == S_COMMIT) && (op_q == OP_WR);
  assign err       = (state_q == S_ERR);
`ifdef RTC_VL_CHECK_EN
  assign vl_flag   = vl_q;
`else
  assign vl_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_access_sched.sv
// tb/tb_rtc_access_sched.sv - directed bench for rtc_access_sched with a small I2C engine model
module tb_rtc_access_sched;

  localparam int P  = 300;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [23:0] wr_time = '0;
  logic [31:0] wr_date = '0;
  logic        wr_ready, i2c_req, i2c_rnw, read_done, wr_done, err, vl_flag;
  logic [7:0]  i2c_addr, i2c_wdata;
  logic        i2c_busy = 1'b0, i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic [7:0]  i2c_rdata = 8'h00;
  logic [23:0] time_read;
  logic [31:0] date_read;

  int total = 0;
  int bad   = 0;

  rtc_access_sched #(.CLK_HZ(P), .POLL_HZ(1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ready(wr_ready),
    .wr_time(wr_time), .wr_date(wr_date),
    .i2c_req(i2c_req), .i2c_rnw(i2c_rnw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .i2c_ack_err(i2c_ack_err),
    .time_read(time_read), .date_read(date_read),
    .read_done(read_done), .wr_done(wr_done), .err(err), .vl_flag(vl_flag)
  );

  always #5 clk = ~clk;

  // Engine model and event log
  logic [7:0] rd_bytes [8];
  logic [7:0] nack_addr = 8'h00;
  logic       hang = 1'b0;
  logic [7:0] cur_addr = 8'h00;
  logic [1:0] lat = 2'd0;
  logic [7:0] log_addr  [256];
  logic       log_rnw   [256];
  logic [7:0] log_wdata [256];
  int         log_cyc   [256];
  int         log_n = 0, unstable = 0;
  int         cyc = 0, rd_cnt = 0, wd_cnt = 0, er_cnt = 0;
  int         req_cyc = 0, done_cyc = 0, rdone_cyc = 0, wdone_cyc = 0, err_cyc = 0;
  logic       err_wr_ready = 1'b0;
  wire  [2:0] cur_idx = 3'(cur_addr - 8'd2);

  always @(posedge clk) begin
    if (rst) begin
      i2c_busy    <= 1'b0;
      i2c_done    <= 1'b0;
      i2c_ack_err <= 1'b0;
      lat         <= 2'd0;
    end else begin
      i2c_done    <= 1'b0;
      i2c_ack_err <= 1'b0;
      if (i2c_req) begin
        i2c_busy          <= 1'b1;
        lat               <= 2'd2;
        cur_addr          <= i2c_addr;
        log_addr[log_n]   <= i2c_addr;
        log_rnw[log_n]    <= i2c_rnw;
        log_wdata[log_n]  <= i2c_wdata;
        log_cyc[log_n]    <= cyc;
        log_n             <= log_n + 1;
      end else if (i2c_busy && !hang) begin
        if (lat == 2'd0) begin
          i2c_busy    <= 1'b0;
          i2c_done    <= 1'b1;
          i2c_rdata   <= rd_bytes[cur_idx];
          i2c_ack_err <= (cur_addr == nack_addr);
          if (i2c_addr !== cur_addr) unstable <= unstable + 1;
        end else begin
          lat <= lat - 2'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i2c_req)   req_cyc  <= cyc;
    if (i2c_done)  done_cyc <= cyc;
    if (read_done) begin rd_cnt <= rd_cnt + 1; rdone_cyc <= cyc; end
    if (wr_done)   begin wd_cnt <= wd_cnt + 1; wdone_cyc <= cyc; end
    if (err)       begin er_cnt <= er_cnt + 1; err_cyc <= cyc; err_wr_ready <= wr_ready; end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    wr_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (wr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready);
    end
    total++;
    if ({i2c_req, i2c_rnw, i2c_addr, i2c_wdata, time_read, date_read, read_done, wr_done, err, vl_flag} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h %h %b%b%b%b want=all zero", time_read, date_read, i2c_req, read_done, err, vl_flag);
    end
  endtask

  task automatic test_idle_poll();
    int b_rd, b_er, base, b_un;
    reset_dut();
    rd_bytes = '{8'h45, 8'h30, 8'h12, 8'h25, 8'h03, 8'h86, 8'h24, 8'h00};
    b_rd = rd_cnt; b_er = er_cnt; base = log_n; b_un = unstable;
    for (int i = 0; i < P + 100 && rd_cnt == b_rd; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++;
    if (rd_cnt - b_rd !== 1) begin bad++; $display("FAIL poll_read_done count got=%0d want=1", rd_cnt - b_rd); end
    total++;
    if (time_read !== 24'h123045) begin bad++; $display("FAIL poll_time got=%h want=123045", time_read); end
    total++;
    if (date_read !== 32'h24062503) begin bad++; $display("FAIL poll_date got=%h want=24062503", date_read); end
    total++;
    if (log_n - base !== 7) begin bad++; $display("FAIL poll_req_count got=%0d want=7", log_n - base); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({log_rnw[base+i], log_addr[base+i]} !== {1'b1, 8'(2 + i)}) begin
        bad++; $display("FAIL poll_req%0d got rnw=%b addr=%h want rnw=1 addr=%h", i, log_rnw[base+i], log_addr[base+i], 8'(2 + i));
      end
    end
    total++;
    if (rdone_cyc - done_cyc !== 2) begin bad++; $display("FAIL poll_commit_latency got=%0d want=2", rdone_cyc - done_cyc); end
    total++;
    if (unstable - b_un !== 0 || er_cnt - b_er !== 0) begin
      bad++; $display("FAIL poll_stable_noerr got unstable=%0d err=%0d want 0 0", unstable - b_un, er_cnt - b_er);
    end
  endtask

  task automatic test_write_priority();
    int b_rd, b_wd, base;
    logic [7:0] exp_w [7];
    exp_w = '{8'h47, 8'h59, 8'h23, 8'h28, 8'h06, 8'h12, 8'h99};
    reset_dut();
    rd_bytes = '{8'h59, 8'h58, 8'h23, 8'h31, 8'h06, 8'h12, 8'h99, 8'h00};
    b_rd = rd_cnt; b_wd = wd_cnt; base = log_n;
    repeat (P - 1) @(posedge clk);
    @(negedge clk);
    wr_req  = 1'b1;
    wr_time = 24'hA3D9C7;
    wr_date = 32'h9992E8FE;
    @(negedge clk);
    wr_req = 1'b0;
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL wp_ready_drop got=%b want=0", wr_ready); end
    for (int i = 0; i < 400 && rd_cnt == b_rd; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++;
    if (log_n - base !== 14) begin bad++; $display("FAIL wp_req_count got=%0d want=14", log_n - base); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({log_rnw[base+i], log_addr[base+i], log_wdata[base+i]} !== {1'b0, 8'(2 + i), exp_w[i]}) begin
        bad++; $display("FAIL wp_write%0d got rnw=%b addr=%h data=%h want rnw=0 addr=%h data=%h",
                        i, log_rnw[base+i], log_addr[base+i], log_wdata[base+i], 8'(2 + i), exp_w[i]);
      end
      total++;
      if ({log_rnw[base+7+i], log_addr[base+7+i]} !== {1'b1, 8'(2 + i)}) begin
        bad++; $display("FAIL wp_read%0d got rnw=%b addr=%h want rnw=1 addr=%h", i, log_rnw[base+7+i], log_addr[base+7+i], 8'(2 + i));
      end
    end
    total++;
    if (wd_cnt - b_wd !== 1 || rd_cnt - b_rd !== 1) begin
      bad++; $display("FAIL wp_pulses got wr_done=%0d read_done=%0d want 1 1", wd_cnt - b_wd, rd_cnt - b_rd);
    end
    total++;
    if (!(wdone_cyc < log_cyc[base+7] && wdone_cyc > log_cyc[base+6])) begin
      bad++; $display("FAIL wp_order got wr_done_cyc=%0d first_read_cyc=%0d want wr_done before reads", wdone_cyc, log_cyc[base+7]);
    end
    total++;
    if ({time_read, date_read, wr_ready} !== {24'h235859, 32'h99123106, 1'b1}) begin
      bad++; $display("FAIL wp_result got time=%h date=%h ready=%b want 235859 99123106 1", time_read, date_read, wr_ready);
    end
  endtask

  task automatic test_nack();
    int b_rd, b_er, base;
    reset_dut();
    nack_addr = 8'h00;
    rd_bytes = '{8'h45, 8'h30, 8'h12, 8'h25, 8'h03, 8'h86, 8'h24, 8'h00};
    b_rd = rd_cnt;
    for (int i = 0; i < P + 100 && rd_cnt == b_rd; i++) @(negedge clk);
    rd_bytes = '{8'h11, 8'h22, 8'h13, 8'h14, 8'h05, 8'h09, 8'h31, 8'h00};
    nack_addr = 8'h05;
    b_rd = rd_cnt; b_er = er_cnt; base = log_n;
    for (int i = 0; i < P + 100 && er_cnt == b_er; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++;
    if (er_cnt - b_er !== 1 || rd_cnt - b_rd !== 0) begin
      bad++; $display("FAIL nack_pulses got err=%0d read_done=%0d want 1 0", er_cnt - b_er, rd_cnt - b_rd);
    end
    total++;
    if ({time_read, date_read} !== {24'h123045, 32'h24062503}) begin
      bad++; $display("FAIL nack_hold got time=%h date=%h want 123045 24062503", time_read, date_read);
    end
    total++;
    if (log_n - base !== 4) begin bad++; $display("FAIL nack_idle got requests=%0d want=4", log_n - base); end
    nack_addr = 8'h00;
    b_rd = rd_cnt;
    for (int i = 0; i < P + 100 && rd_cnt == b_rd; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if ({time_read, date_read} !== {24'h132211, 32'h31091405}) begin
      bad++; $display("FAIL nack_recover got time=%h date=%h want 132211 31091405", time_read, date_read);
    end
  endtask

  task automatic test_timeout();
    int b_er, b_wd, base;
    reset_dut();
    hang = 1'b1;
    b_er = er_cnt; base = log_n;
    for (int i = 0; i < P + 50 && log_n == base; i++) @(negedge clk);
    for (int i = 0; i < TO + 20 && er_cnt == b_er; i++) @(negedge clk);
    total++;
    if (er_cnt - b_er !== 1) begin bad++; $display("FAIL to_read_err got=%0d want=1", er_cnt - b_er); end
    total++;
    if (err_cyc - req_cyc !== TO) begin bad++; $display("FAIL to_read_delay got=%0d want=%0d", err_cyc - req_cyc, TO); end
    reset_dut();
    b_er = er_cnt; b_wd = wd_cnt; base = log_n;
    @(negedge clk);
    wr_req = 1'b1; wr_time = 24'h101010; wr_date = 32'h24010101;
    @(negedge clk);
    wr_req = 1'b0;
    for (int i = 0; i < TO + 30 && er_cnt == b_er; i++) @(negedge clk);
    total++;
    if (er_cnt - b_er !== 1 || wd_cnt - b_wd !== 0 || log_rnw[base] !== 1'b0) begin
      bad++; $display("FAIL to_write_err got err=%0d wr_done=%0d rnw=%b want 1 0 0", er_cnt - b_er, wd_cnt - b_wd, log_rnw[base]);
    end
    total++;
    if (err_cyc - req_cyc !== TO) begin bad++; $display("FAIL to_write_delay got=%0d want=%0d", err_cyc - req_cyc, TO); end
    total++;
    if ({err_wr_ready, wr_ready} !== 2'b11) begin
      bad++; $display("FAIL to_write_ready got at_err=%b now=%b want 1 1", err_wr_ready, wr_ready);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int b_rd, b_er, base;
    reset_dut();
    rd_bytes = '{8'h45, 8'h30, 8'h12, 8'h25, 8'h03, 8'h86, 8'h24, 8'h00};
    b_rd = rd_cnt; b_er = er_cnt; base = log_n;
    for (int i = 0; i < P + 100 && log_n - base < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({i2c_req, i2c_rnw, i2c_addr, i2c_wdata, time_read, date_read, read_done, wr_done, err, vl_flag, wr_ready} !== {84'h0, 1'b1}) begin
      bad++; $display("FAIL rmb_outputs got req=%b addr=%h time=%h ready=%b want reset values", i2c_req, i2c_addr, time_read, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (rd_cnt - b_rd !== 0 || er_cnt - b_er !== 0 || time_read !== 24'h0) begin
      bad++; $display("FAIL rmb_pulses got read_done=%0d err=%0d time=%h want 0 0 0", rd_cnt - b_rd, er_cnt - b_er, time_read);
    end
  endtask

  task automatic test_vl();
    int b_rd, b_wd;
    reset_dut();
    rd_bytes = '{8'hC5, 8'h30, 8'h12, 8'h25, 8'h03, 8'h86, 8'h24, 8'h00};
    b_rd = rd_cnt;
    for (int i = 0; i < P + 100 && rd_cnt == b_rd; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (time_read[7:0] !== 8'h45) begin bad++; $display("FAIL vl_sec_mask got=%h want=45", time_read[7:0]); end
    total++;
`ifdef RTC_VL_CHECK_EN
    if (vl_flag !== 1'b1) begin bad++; $display("FAIL vl_set got=%b want=1", vl_flag); end
`else
    if (vl_flag !== 1'b0) begin bad++; $display("FAIL vl_tied got=%b want=0", vl_flag); end
`endif
    b_wd = wd_cnt;
    wr_req = 1'b1; wr_time = 24'h080000; wr_date = 32'h25010101;
    @(negedge clk);
    wr_req = 1'b0;
    for (int i = 0; i < 200 && wd_cnt == b_wd; i++) @(negedge clk);
    total++;
    if (wd_cnt - b_wd !== 1 || vl_flag !== 1'b0) begin
      bad++; $display("FAIL vl_clear got wr_done=%0d vl=%b want 1 0", wd_cnt - b_wd, vl_flag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_poll();
    test_write_priority();
    test_nack();
    test_timeout();
    test_reset_mid_burst();
    test_vl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_access_sched.md
# rtc_access_sched

Scheduler for the shared PCF8563 I2C register engine. It issues periodic 7-register time/date burst reads and host-requested set-time burst writes, and arbitrates between the two. It owns all sequencing: register addressing, byte counting, masking and error/timeout handling. It presents atomically updated `time_read`/`date_read` plus completion pulses to the display and UART-report paths.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `POLL_HZ`, 4: periodic read rate.
- `TIMEOUT_CYC`, 100_000: maximum wait for one `i2c_done` before abort.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_req` in 1: set-time request; sampled only while `wr_ready`=1.
- `wr_ready` out 1: scheduler can accept `wr_req`.
- `wr_time` in 24: {hour, min, sec} BCD, captured with `wr_req`.
- `wr_date` in 32: {year, month, day, weekday} BCD, captured with `wr_req`.
- `i2c_req` out 1: one-cycle start of a single-register transaction.
- `i2c_rnw` out 1: 1 = read, 0 = write; valid with `i2c_req`.
- `i2c_addr` out 8: PCF8563 register address.
- `i2c_wdata` out 8: write byte.
- `i2c_busy` in 1: engine busy.
- `i2c_done` in 1: one-cycle transaction complete.
- `i2c_rdata` in 8: read byte; valid with `i2c_done`.
- `i2c_ack_err` in 1: NACK flag; valid with `i2c_done`.
- `time_read` out 24: {hour, min, sec}.
- `date_read` out 32: {year, month, day, weekday}.
- `read_done` out 1: one-cycle pulse on committing a read burst.
- `wr_done` out 1: one-cycle pulse on completing a write burst.
- `err` out 1: one-cycle pulse on an aborted burst (NACK or timeout).
- `vl_flag` out 1: voltage-low indicator (see Configuration).

## Operation
- Registers 0x02..0x08 (sec, min, hour, day, weekday, month, year), ascending, one engine transaction per byte, byte counter 0..6.
- Poll timer: counts 0..`CLK_HZ/POLL_HZ`-1 and sets `poll_pend` on wrap. At most one pending poll; extra wraps are absorbed.
- `wr_req`&&`wr_ready` captures the payload, sets `wr_pend` and drops `wr_ready` until `wr_done` or `err`.
- Arbitration happens in IDLE only. `wr_pend` beats `poll_pend`. A poll that arrives during a write is served immediately after it. No preemption mid-burst.
- FSM states:
  - IDLE → ARB when any request is pending.
  - ARB → ISSUE: latch the op, clear that op's pend flag, counter = 0.
  - ISSUE: wait for `i2c_busy`=0, pulse `i2c_req`, → WAIT.
  - WAIT, on `i2c_done`: NACK → ERR; otherwise store the byte (read), then → NEXT.
  - WAIT, timeout counter reaching `TIMEOUT_CYC` → ERR.
  - NEXT: counter==6 → COMMIT; otherwise increment and → ISSUE.
  - COMMIT: pulse `read_done` or `wr_done`, → IDLE.
  - ERR: pulse `err`, → IDLE.
- Read masks: sec&0x7F, min&0x7F, hour&0x3F, day&0x3F, weekday&0x07, month&0x1F (century bit dropped), year unmasked.
- Read bytes go into a 56-bit shadow register. `time_read`/`date_read` update only in COMMIT, so an aborted read leaves the outputs unchanged.
- Write bytes are taken from the captured payload with the same masks applied. Month is written with century bit = 0. An aborted write is not retried.

## Timing
- Reset values: all outputs 0 except `wr_ready`=1. FSM = IDLE, timer = 0, pend flags cleared.
- Reset mid-burst: abandon the burst immediately, no pulses, `i2c_req` low the next cycle. The engine shares `rst`.
- `i2c_req` asserts one cycle after entering ISSUE with `i2c_busy` low.
- `i2c_addr`/`i2c_rnw`/`i2c_wdata` are held stable from `i2c_req` until `i2c_done`.
- Outputs update, and `read_done` pulses, 2 cycles after the 7th `i2c_done` (NEXT, then COMMIT).
- `wr_ready` rises in the same cycle as `wr_done`/`err`. A `wr_req` in that cycle is ignored.
- Timeout counter resets on every `i2c_req`.

## Configuration
- `RTC_VL_CHECK_EN` defined:
  - In COMMIT, `vl_flag` ← raw seconds bit 7.
  - A completed write clears `vl_flag` in COMMIT.
- `RTC_VL_CHECK_EN` undefined: `vl_flag` is tied 0 and no VL logic is synthesised.

## Structure
- Package `rtc_sched_pkg`: register addresses 0x02..0x08, field masks, `NUM_REGS`=7, FSM state enum, op enum (OP_RD, OP_WR).
- Sub-module `rtc_poll_timer`: parameterised tick generator producing a one-cycle `tick`. Pend flags, arbitration and FSM stay in the top.

## Test plan
- Idle poll:
  - Stimulus: engine model returns 0x45,0x30,0x12,0x25,0x03,0x86,0x24.
  - Required: `time_read`=0x123045, `date_read`=0x24062503, a single `read_done` pulse, 7 ascending `i2c_req` with addresses 0x02..0x08.
- Write priority:
  - Stimulus: `wr_req` and poll tick in the same cycle.
  - Required: 7 writes of the masked payload first, then `wr_done`, then 7 reads, then `read_done`.
- NACK on byte 3 of a read:
  - Required: `err` pulse, `time_read`/`date_read` unchanged, FSM back in IDLE, next poll succeeds.
- Timeout:
  - Stimulus: engine never returns `i2c_done`.
  - Required: `err` exactly `TIMEOUT_CYC` cycles after `i2c_req`; a write also re-raises `wr_ready`.
- Reset mid-burst:
  - Stimulus: `rst` asserted during byte 4.
  - Required: all outputs at reset values, no `read_done`/`err` pulse.
- `RTC_VL_CHECK_EN` defined:
  - Stimulus: seconds byte 0xC5.
  - Required: `time_read[7:0]`=0x45, `vl_flag`=1; a subsequent write clears `vl_flag`.
